// File: rtl/mem_fill_seq.sv
// mem_fill_seq: memory-initialisation sequencer for a single-port RAM.
// An accepted start captures mode, base address, length and fill value. The block
// then issues one write per clock: addr = base + i (wrapping), with data chosen by mode.
// Optional feature: define MEMFILL_CHECKSUM_EN to add a running checksum output that
// sums every data word written.
// Reset rst_n is asynchronous and active-high (1 = reset); this matches the
// surrounding codebase.
module mem_fill_seq #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              wren,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done
`ifdef MEMFILL_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_IDENT = 2'b00;
  localparam logic [1:0] MODE_CONST = 2'b01;
  localparam logic [1:0] MODE_DESC  = 2'b10;

  localparam logic [ADDR_W:0]   IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   IDX_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [1:0]        mode_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   idx_q;
  logic [DATA_W-1:0] fill_q;
  logic              accept;
  logic              last_write;
  logic [ADDR_W:0]   idx_next;

  // Data word for index i of an n-long fill. The index is truncated or
  // zero-extended to DATA_W.
  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [ADDR_W:0]   i,
    input logic [ADDR_W:0]   n,
    input logic [DATA_W-1:0] f
  );
    logic [ADDR_W:0] desc;
    desc = n - i - IDX_ONE;
    case (m)
      MODE_IDENT: pattern = DATA_W'(i);
      MODE_CONST: pattern = f;
      MODE_DESC:  pattern = DATA_W'(desc);
      default:    pattern = DATA_W'(i) ^ f;
    endcase
  endfunction

  // start is honoured only in IDLE and DONE. The write currently on the port is the
  // last one when the next index would reach the latched count.
  assign accept     = start && (state != S_WRITE);
  assign idx_next   = idx_q + IDX_ONE;
  assign last_write = (idx_next == cnt_q);

  // Sequencer FSM: every output is registered here, so the RAM port is glitch-free.
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= S_IDLE;
      mode_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      fill_q <= '0;
      wren   <= 1'b0;
      addr   <= '0;
      data   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (accept) begin
      // Latch the request. The first write goes out on this same edge.
      mode_q <= mode;
      cnt_q  <= count;
      fill_q <= fill_val;
      idx_q  <= '0;
      addr   <= base_addr;
      if (count != IDX_ZERO) begin
        state <= S_WRITE;
        wren  <= 1'b1;
        busy  <= 1'b1;
        done  <= 1'b0;
        data  <= pattern(mode, IDX_ZERO, count, fill_val);
      end else begin
        state <= S_DONE;
        wren  <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end else begin
      case (state)
        S_WRITE: begin
          if (abort) begin
            // abort takes priority over the final-write transition.
            state <= S_IDLE;
            wren  <= 1'b0;
            busy  <= 1'b0;
          end else if (last_write) begin
            state <= S_DONE;
            wren  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx_q <= idx_next;
            addr  <= addr + ADDR_ONE;
            data  <= pattern(mode_q, idx_next, cnt_q, fill_q);
          end
        end
        S_IDLE, S_DONE: ;
        default: begin
          state <= S_IDLE;
          wren  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEMFILL_CHECKSUM_EN
  // Running checksum. The RAM commits the word on every edge that sees wren=1, aborted
  // edges included, so an aborted fill keeps the sum of the words actually written.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (state == S_WRITE) begin
      checksum <= checksum + data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_fill_seq.sv
// tb_mem_fill_seq: directed tests for mem_fill_seq with ADDR_W=8 and DATA_W=8.
// Build with MEMFILL_CHECKSUM_EN defined to include the checksum checks.
module tb_mem_fill_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [7:0] base_addr;
  logic [8:0] count;
  logic [7:0] fill_val;
  logic       abort;
  logic       wren;
  logic [7:0] addr;
  logic [7:0] data;
  logic       busy;
  logic       done;
`ifdef MEMFILL_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  mem_fill_seq #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .count     (count),
    .fill_val  (fill_val),
    .abort     (abort),
    .wren      (wren),
    .addr      (addr),
    .data      (data),
    .busy      (busy),
    .done      (done)
`ifdef MEMFILL_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge. Outputs are sampled 1 time unit after the edge, and
  // inputs are changed at that same point, so they are well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start request and advance to the accept edge.
  task automatic launch(input logic [1:0] m, input logic [7:0] b,
                        input logic [8:0] n, input logic [7:0] f);
    mode = m; base_addr = b; count = n; fill_val = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    checks++;
    if ({wren, addr, data, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_async got wren=%b addr=%h data=%h busy=%b done=%b exp all 0",
               wren, addr, data, busy, done);
    end
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({wren, addr, data, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_idle got wren=%b addr=%h data=%h busy=%b done=%b exp all 0",
               wren, addr, data, busy, done);
    end
  endtask

  task automatic test_identity_256();
    launch(2'b00, 8'h00, 9'd256, 8'h00);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] ek;
      ek = k[7:0];
      checks++;
      if (wren !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || addr !== ek || data !== ek) begin
        errors++;
        $display("FAIL ident256_write%0d got wren=%b busy=%b done=%b addr=%h data=%h exp 1 1 0 %h %h",
                 k, wren, busy, done, addr, data, ek, ek);
      end
      tick();
    end
    checks++;
    if (wren !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL ident256_done got wren=%b busy=%b done=%b exp 0 0 1", wren, busy, done);
    end
`ifdef MEMFILL_CHECKSUM_EN
    checks++;
    if (checksum !== 8'h80) begin
      errors++;
      $display("FAIL ident256_checksum got %h exp 80", checksum);
    end
`endif
  endtask

  task automatic test_wrap_base();
    logic [7:0] exp_addr [4];
    int busy_cycles;
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
    busy_cycles = 0;
    launch(2'b00, 8'hFE, 9'd4, 8'h00);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ek;
      ek = k[7:0];
      if (busy === 1'b1) busy_cycles++;
      checks++;
      if (wren !== 1'b1 || done !== 1'b0 || addr !== exp_addr[k] || data !== ek) begin
        errors++;
        $display("FAIL wrap_write%0d got wren=%b done=%b addr=%h data=%h exp 1 0 %h %h",
                 k, wren, done, addr, data, exp_addr[k], ek);
      end
      tick();
    end
    if (busy === 1'b1) busy_cycles++;
    checks++;
    if (busy_cycles != 4 || done !== 1'b1 || wren !== 1'b0) begin
      errors++;
      $display("FAIL wrap_busy_len got busy_cycles=%0d done=%b wren=%b exp 4 1 0",
               busy_cycles, done, wren);
    end
`ifdef MEMFILL_CHECKSUM_EN
    checks++;
    if (checksum !== 8'h06) begin
      errors++;
      $display("FAIL wrap_checksum got %h exp 06", checksum);
    end
`endif
  endtask

  task automatic test_const_then_desc();
    launch(2'b01, 8'h40, 9'd3, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] ea;
      ea = 8'h40 + k[7:0];
      checks++;
      if (wren !== 1'b1 || addr !== ea || data !== 8'hA5) begin
        errors++;
        $display("FAIL const_write%0d got wren=%b addr=%h data=%h exp 1 %h a5",
                 k, wren, addr, data, ea);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || wren !== 1'b0) begin
      errors++;
      $display("FAIL const_done got done=%b wren=%b exp 1 0", done, wren);
    end
`ifdef MEMFILL_CHECKSUM_EN
    checks++;
    if (checksum !== 8'hEF) begin
      errors++;
      $display("FAIL const_checksum got %h exp ef", checksum);
    end
`endif
    // Restart from DONE in descending mode.
    launch(2'b10, 8'h50, 9'd3, 8'h00);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] ea;
      logic [7:0] ed;
      ea = 8'h50 + k[7:0];
      ed = 8'd2 - k[7:0];
      checks++;
      if (wren !== 1'b1 || done !== 1'b0 || addr !== ea || data !== ed) begin
        errors++;
        $display("FAIL desc_write%0d got wren=%b done=%b addr=%h data=%h exp 1 0 %h %h",
                 k, wren, done, addr, data, ea, ed);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || wren !== 1'b0) begin
      errors++;
      $display("FAIL desc_done got done=%b wren=%b exp 1 0", done, wren);
    end
  endtask

  task automatic test_xor();
    launch(2'b11, 8'h20, 9'd3, 8'h0F);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] ea;
      logic [7:0] ed;
      ea = 8'h20 + k[7:0];
      ed = k[7:0] ^ 8'h0F;
      checks++;
      if (wren !== 1'b1 || addr !== ea || data !== ed) begin
        errors++;
        $display("FAIL xor_write%0d got wren=%b addr=%h data=%h exp 1 %h %h",
                 k, wren, addr, data, ea, ed);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL xor_done got done=%b exp 1", done);
    end
  endtask

  task automatic test_abort();
    launch(2'b00, 8'h00, 9'd100, 8'h00);
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (wren !== 1'b1 || addr !== 8'h04 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_fifth_write got wren=%b addr=%h done=%b exp 1 04 0", wren, addr, done);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop got wren=%b busy=%b done=%b exp 0 0 0", wren, busy, done);
    end
`ifdef MEMFILL_CHECKSUM_EN
    checks++;
    if (checksum !== 8'h0A) begin
      errors++;
      $display("FAIL abort_checksum got %h exp 0a", checksum);
    end
`endif
    tick();
    checks++;
    if (wren !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got wren=%b done=%b exp 0 0", wren, done);
    end
    // An abort on the final write wins over completion.
    launch(2'b00, 8'h30, 9'd2, 8'h00);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_priority got wren=%b busy=%b done=%b exp 0 0 0", wren, busy, done);
    end
  endtask

  task automatic test_count_zero();
    launch(2'b00, 8'h10, 9'd0, 8'h00);
    checks++;
    if (wren !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL count0_idle got wren=%b busy=%b done=%b exp 0 0 1", wren, busy, done);
    end
    launch(2'b00, 8'h10, 9'd0, 8'h00);
    checks++;
    if (wren !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL count0_done got wren=%b done=%b exp 0 1", wren, done);
    end
  endtask

  task automatic test_start_during_write();
    launch(2'b00, 8'h10, 9'd5, 8'h00);
    // Changes to the inputs after accept must not disturb the fill.
    mode = 2'b01; base_addr = 8'h99; count = 9'd7; fill_val = 8'h55;
    for (int k = 0; k < 5; k++) begin
      logic [7:0] ea;
      ea = 8'h10 + k[7:0];
      checks++;
      if (wren !== 1'b1 || addr !== ea || data !== k[7:0]) begin
        errors++;
        $display("FAIL startwr_write%0d got wren=%b addr=%h data=%h exp 1 %h %h",
                 k, wren, addr, data, ea, k[7:0]);
      end
      start = (k == 2);
      tick();
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || wren !== 1'b0) begin
      errors++;
      $display("FAIL startwr_done got done=%b wren=%b exp 1 0", done, wren);
    end
  endtask

  task automatic test_reset_mid_fill();
    launch(2'b00, 8'h00, 9'd50, 8'h00);
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({wren, addr, data, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid_async got wren=%b addr=%h data=%h busy=%b done=%b exp all 0",
               wren, addr, data, busy, done);
    end
`ifdef MEMFILL_CHECKSUM_EN
    checks++;
    if (checksum !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_checksum got %h exp 00", checksum);
    end
`endif
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release got wren=%b busy=%b done=%b exp 0 0 0", wren, busy, done);
    end
  endtask

  initial begin
    start = 1'b0; mode = 2'b00; base_addr = '0; count = '0; fill_val = '0; abort = 1'b0;
    test_reset();
    test_identity_256();
    test_wrap_base();
    test_const_then_desc();
    test_xor();
    test_abort();
    test_count_zero();
    test_start_during_write();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
